// File: rtl/tr_seq_pkg.sv
// Shared definitions for the transfer-mux sequencer: FSM encodings and the
// fixed-point data width helper.
package tr_seq_pkg;

   localparam int I_WIDTH_DEF = 8;
   localparam int F_WIDTH_DEF = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   function automatic int data_width(input int i_width, input int f_width);
      return i_width + f_width;
   endfunction

   localparam int DATA_WIDTH = data_width(I_WIDTH_DEF, F_WIDTH_DEF);

endpackage

// File: rtl/tr_mux_sequencer_if.sv
// Control, mux-side and stream-side signals of the transfer-mux sequencer.
// The slave modport is the sequencer itself.
interface tr_mux_sequencer_if #(
   parameter int DATA_WIDTH = tr_seq_pkg::DATA_WIDTH,
   parameter int SEL_WIDTH  = 4,
   parameter int LEN_WIDTH  = 4
);
   logic                         start_i;
   logic [LEN_WIDTH-1:0]         len_i;
   logic                         busy_o;
   logic                         done_o;
   logic                         err_o;
   logic [SEL_WIDTH-1:0]         sel_mux_tr_o;
   logic                         sel_mux_tr_ld_o;
   logic                         sel_mux_tr_rst_o;
   logic signed [DATA_WIDTH-1:0] tr_data_i;
   logic signed [DATA_WIDTH-1:0] out_data_o;
   logic                         out_valid_o;
   logic                         out_ready_i;
   logic                         out_last_o;

   modport slave (
      input  start_i, len_i, tr_data_i, out_ready_i,
      output busy_o, done_o, err_o, sel_mux_tr_o, sel_mux_tr_ld_o,
             sel_mux_tr_rst_o, out_data_o, out_valid_o, out_last_o
   );

   modport master (
      output start_i, len_i, tr_data_i, out_ready_i,
      input  busy_o, done_o, err_o, sel_mux_tr_o, sel_mux_tr_ld_o,
             sel_mux_tr_rst_o, out_data_o, out_valid_o, out_last_o
   );
endinterface

// File: rtl/tr_skid_fifo.sv
// Two-entry FIFO holding captured mux words (data plus last flag) until the
// downstream stream accepts them.
module tr_skid_fifo #(
   parameter int WIDTH = 17
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [1:0]       count,
   output logic [WIDTH-1:0] head
);
   logic [WIDTH-1:0] mem_r [2];
   logic             wr_ptr_r;
   logic             rd_ptr_r;
   logic [1:0]       count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Qualify requests; a push into a full FIFO is only legal with a pop.
   always_comb begin
      pop_ok_s  = pop && (count_r != 2'd0);
      push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_r[0] <= '0;
         mem_r[1] <= '0;
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= ~wr_ptr_r;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         count_r <= count_r + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
      end
   end

   assign count = count_r;
   assign head  = mem_r[rd_ptr_r];
endmodule

// File: rtl/tr_mux_sequencer.sv
// Walks the transfer-mux select 0..len-1, captures each selected word one
// cycle after its load and streams it out with credit-based back-pressure.
module tr_mux_sequencer
   import tr_seq_pkg::*;
#(
   parameter int I_WIDTH          = 8,
   parameter int F_WIDTH          = 8,
   parameter int LEN_TRANSFER     = 10,
   parameter int MAX_LEN_TRANSFER = 10,
   parameter int SEL_MUX_TR_WIDTH = $clog2(MAX_LEN_TRANSFER),
   parameter int LEN_WIDTH        = $clog2(MAX_LEN_TRANSFER + 1)
) (
   input logic               clk_i,
   input logic               rst_i,
   tr_mux_sequencer_if.slave bus
);
   localparam int DW = data_width(I_WIDTH, F_WIDTH);
   localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(LEN_TRANSFER);
   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

   logic [1:0]                  state_r;
   logic [LEN_WIDTH-1:0]        idx_r;
   logic [LEN_WIDTH-1:0]        len_r;
   logic [SEL_MUX_TR_WIDTH-1:0] last_sel_r;
   logic                        inflight_r;
   logic                        inflight_last_r;
   logic                        err_r;
   logic                        rst_d_r;
   logic [1:0]                  fifo_count_s;
   logic [DW:0]                 fifo_head_s;
   logic [2:0]                  occupancy_s;
   logic                        pop_s;
   logic                        credit_ok_s;
   logic                        issue_s;
   logic                        drain_done_s;
   logic                        len_ok_s;
   logic                        is_last_idx_s;

   // Credit and issue decisions depend on this cycle's pop, so ld is combinational.
   always_comb begin
      pop_s         = (fifo_count_s != 2'd0) && bus.out_ready_i;
      occupancy_s   = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
      credit_ok_s   = occupancy_s < 3'd2;
      len_ok_s      = (bus.len_i != '0) && (bus.len_i <= LEN_MAX);
      is_last_idx_s = (idx_r == (len_r - LEN_ONE));
      if ((state_r == ST_ISSUE) && (idx_r < len_r) && credit_ok_s) begin
         issue_s = 1'b1;
      end else begin
         issue_s = 1'b0;
      end
      // Leave DRAIN on the edge that empties the FIFO so done lands at len+3.
      drain_done_s = !inflight_r &&
                     ((fifo_count_s == 2'd0) || ((fifo_count_s == 2'd1) && pop_s));
   end

   // Sequencer FSM, select index and capture tracking.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r         <= ST_IDLE;
         idx_r           <= '0;
         len_r           <= '0;
         last_sel_r      <= '0;
         inflight_r      <= 1'b0;
         inflight_last_r <= 1'b0;
         err_r           <= 1'b0;
         rst_d_r         <= 1'b1;
      end else begin
         rst_d_r         <= 1'b0;
         err_r           <= 1'b0;
         inflight_r      <= issue_s;
         inflight_last_r <= issue_s && is_last_idx_s;
         if (issue_s) begin
            last_sel_r <= idx_r[SEL_MUX_TR_WIDTH-1:0];
            idx_r      <= idx_r + LEN_ONE;
         end
         case (state_r)
            ST_IDLE: begin
               if (bus.start_i) begin
                  if (len_ok_s) begin
                     len_r   <= bus.len_i;
                     idx_r   <= '0;
                     state_r <= ST_ISSUE;
                  end else begin
                     err_r <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               if (issue_s && is_last_idx_s) begin
                  state_r <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (drain_done_s) begin
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               last_sel_r <= '0;
               state_r    <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   tr_skid_fifo #(
      .WIDTH(DW + 1)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push      (inflight_r),
      .push_data ({inflight_last_r, bus.tr_data_i}),
      .pop       (pop_s),
      .count     (fifo_count_s),
      .head      (fifo_head_s)
   );

   assign bus.busy_o           = (state_r != ST_IDLE);
   assign bus.done_o           = (state_r == ST_DONE);
   assign bus.err_o            = err_r;
   assign bus.sel_mux_tr_ld_o  = issue_s;
   assign bus.sel_mux_tr_o     = issue_s ? idx_r[SEL_MUX_TR_WIDTH-1:0] : last_sel_r;
   assign bus.sel_mux_tr_rst_o = rst_i | rst_d_r | (state_r == ST_DONE);
   assign bus.out_valid_o      = (fifo_count_s != 2'd0);
   assign bus.out_data_o       = $signed(fifo_head_s[DW-1:0]);
   assign bus.out_last_o       = fifo_head_s[DW];
endmodule

// File: tb/tb_tr_mux_sequencer.sv
// Randomised bench for tr_mux_sequencer: a mux model feeds the DUT and a
// queue-based scoreboard checks order, last flags, credit and latency.
module tb_tr_mux_sequencer;
   logic clk = 1'b0;
   logic rst_i;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   t0 = 1000000;
   int   first_ld, first_v, last_v, done_cyc;
   int   done_cnt = 0;
   int   err_cnt = 0;
   int   issued, popped, exp_idx;
   int   rdy_mode = 0;
   int   pat_cnt = 0;
   int   rnd_len;
   int   done0;
   int   cy_m;
   bit   mon_en = 1'b0;
   bit   hold_v = 1'b0;
   logic pop_m;
   logic [15:0] hold_d;
   logic [16:0] exp_q [$];
   logic signed [15:0] mux_in [16];
   logic [3:0] mux_sel_q;

   always #5 clk = ~clk;

   tr_mux_sequencer_if #(.DATA_WIDTH(16), .SEL_WIDTH(4), .LEN_WIDTH(4)) bus ();

   tr_mux_sequencer #(
      .I_WIDTH(8), .F_WIDTH(8), .LEN_TRANSFER(10), .MAX_LEN_TRANSFER(10)
   ) dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus)
   );

   // Behavioural transfer mux: registered select, data valid the cycle after ld.
   always @(posedge clk) begin
      if (bus.sel_mux_tr_rst_o) mux_sel_q <= 4'd0;
      else if (bus.sel_mux_tr_ld_o) mux_sel_q <= bus.sel_mux_tr_o;
   end
   assign bus.tr_data_i = mux_in[mux_sel_q];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Ready driver, changed away from both clock edges.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0: bus.out_ready_i = 1'b1;
            1: bus.out_ready_i = 1'($urandom_range(0, 1));
            2: begin
               bus.out_ready_i = ((pat_cnt % 4) == 0) || ((pat_cnt % 4) == 3);
               pat_cnt++;
            end
            default: bus.out_ready_i = 1'b0;
         endcase
      end
   end

   // Scoreboard: expected stream order, issue order, credit rule, stability.
   always @(negedge clk) begin
      if (!mon_en) begin
         hold_v = 1'b0;
      end else begin
         cy_m  = cyc - t0 + 1;
         pop_m = bus.out_valid_o && bus.out_ready_i;
         if (hold_v)
            check_eq("hold_stable", 32'({bus.out_valid_o, bus.out_data_o}), 32'({1'b1, hold_d}));
         if (bus.sel_mux_tr_ld_o) begin
            check_eq("ld_index", 32'(bus.sel_mux_tr_o), 32'(exp_idx));
            check_eq("credit", 32'((issued - popped - int'(pop_m)) < 2), 32'd1);
            if (first_ld < 0) first_ld = cy_m;
            exp_idx++;
            issued++;
         end
         if (pop_m) begin
            if (exp_q.size() == 0) begin
               check_eq("extra_word", 32'({bus.out_last_o, bus.out_data_o}), 32'h1_0000_0);
            end else begin
               check_eq("word", 32'({bus.out_last_o, bus.out_data_o}), 32'(exp_q[0]));
               void'(exp_q.pop_front());
            end
            popped++;
            if (first_v < 0) first_v = cy_m;
            last_v = cy_m;
         end
         hold_v = bus.out_valid_o && !bus.out_ready_i;
         hold_d = bus.out_data_o;
         if (bus.done_o) begin
            check_eq("done_mux_rst", 32'(bus.sel_mux_tr_rst_o), 32'd1);
            done_cyc = cy_m;
            done_cnt++;
         end
         if (bus.err_o) err_cnt++;
      end
   end

   task automatic clear_score();
      exp_q.delete();
      first_ld = -1; first_v = -1; last_v = -1; done_cyc = -1;
      issued = 0; popped = 0; exp_idx = 0; hold_v = 1'b0;
   endtask

   task automatic run_xfer(input int len, input int mode, input bit timing, input bit mid_start);
      int err0;
      bit got_done;
      clear_score();
      for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), mux_in[i]});
      err0     = err_cnt;
      rdy_mode = mode;
      pat_cnt  = 0;
      t0       = 1000000;
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.len_i   = 4'(len);
      @(posedge clk);
      #1;
      t0 = cyc;
      bus.start_i = 1'b0;
      if (mid_start) begin
         @(posedge clk); #1;
         bus.start_i = 1'b1;
         bus.len_i   = 4'(len + 2);
         @(posedge clk); #1;
         bus.start_i = 1'b0;
      end
      got_done = 1'b0;
      for (int k = 0; k < 300 && !got_done; k++) begin
         @(negedge clk); #1;
         if (done_cyc >= 0) got_done = 1'b1;
      end
      check_eq("done_seen", 32'(got_done), 32'd1);
      check_eq("word_count", popped, len);
      check_eq("issue_count", issued, len);
      check_eq("leftover", exp_q.size(), 0);
      if (timing) begin
         check_eq("first_ld_cycle", first_ld, 1);
         check_eq("first_valid_cycle", first_v, 3);
         check_eq("last_valid_cycle", last_v, len + 2);
         check_eq("done_cycle", done_cyc, len + 3);
      end
      if (mid_start) check_eq("ignored_start_err", err_cnt - err0, 0);
      @(negedge clk); #1;
      check_eq("idle_after_done", 32'({bus.busy_o, bus.done_o}), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mux_in[i] = 16'sd0;
      rst_i = 1'b1;
      bus.start_i = 1'b0;
      bus.len_i   = 4'd0;
      clear_score();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_busy", 32'(bus.busy_o), 32'd0);
      check_eq("rst_done", 32'(bus.done_o), 32'd0);
      check_eq("rst_err", 32'(bus.err_o), 32'd0);
      check_eq("rst_ld", 32'(bus.sel_mux_tr_ld_o), 32'd0);
      check_eq("rst_sel", 32'(bus.sel_mux_tr_o), 32'd0);
      check_eq("rst_valid", 32'(bus.out_valid_o), 32'd0);
      check_eq("rst_out", 32'({bus.out_last_o, bus.out_data_o}), 32'd0);
      check_eq("rst_mux_rst", 32'(bus.sel_mux_tr_rst_o), 32'd1);
      @(posedge clk); #1;
      rst_i  = 1'b0;
      mon_en = 1'b1;

      // Basic directed transfer.
      mux_in[0] = 16'sh0100; mux_in[1] = 16'shFF00;
      mux_in[2] = 16'sh0080; mux_in[3] = 16'sh7FFF;
      run_xfer(4, 0, 1'b1, 1'b0);

      // Rejected starts.
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         bus.start_i = 1'b1;
         bus.len_i   = (b == 0) ? 4'd0 : 4'd11;
         @(posedge clk); #1;
         bus.start_i = 1'b0;
         @(negedge clk); #1;
         check_eq("err_pulse", 32'({bus.err_o, bus.busy_o, bus.sel_mux_tr_ld_o, bus.out_valid_o}), 32'b1000);
         @(negedge clk); #1;
         check_eq("err_clear", 32'({bus.err_o, bus.busy_o, bus.sel_mux_tr_ld_o, bus.out_valid_o}), 32'b0000);
      end

      // Edge lengths.
      mux_in[0] = 16'($urandom);
      run_xfer(1, 0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) mux_in[i] = 16'($urandom);
      run_xfer(10, 0, 1'b1, 1'b0);

      // Back-pressure with the 1-0-0-1 ready pattern.
      for (int i = 0; i < 10; i++) mux_in[i] = 16'(i * 3);
      run_xfer(10, 2, 1'b0, 1'b0);

      // Start during ISSUE must be ignored.
      for (int i = 0; i < 5; i++) mux_in[i] = 16'($urandom);
      run_xfer(5, 0, 1'b1, 1'b1);

      // Abort with two words buffered.
      for (int i = 0; i < 6; i++) mux_in[i] = 16'($urandom);
      clear_score();
      rdy_mode = 3;
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.len_i   = 4'd6;
      @(posedge clk); #1;
      t0 = cyc;
      bus.start_i = 1'b0;
      repeat (4) begin @(negedge clk); #1; end
      check_eq("abort_buffered", 32'({bus.out_valid_o, bus.busy_o}), 32'b11);
      mon_en = 1'b0;
      rst_i  = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      @(negedge clk); #1;
      check_eq("abort_valid", 32'(bus.out_valid_o), 32'd0);
      check_eq("abort_busy", 32'(bus.busy_o), 32'd0);
      check_eq("abort_mux_rst", 32'(bus.sel_mux_tr_rst_o), 32'd1);
      for (int k = 0; k < 4; k++) begin
         check_eq("abort_no_done", 32'({bus.done_o, bus.out_valid_o}), 32'd0);
         @(negedge clk); #1;
      end
      rdy_mode = 0;
      mon_en   = 1'b1;
      for (int i = 0; i < 3; i++) mux_in[i] = 16'($urandom);
      run_xfer(3, 0, 1'b1, 1'b0);

      // Random lengths, data and back-pressure.
      for (int t = 0; t < 8; t++) begin
         rnd_len = $urandom_range(1, 10);
         for (int i = 0; i < 10; i++) mux_in[i] = 16'($urandom);
         run_xfer(rnd_len, 1, 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
